// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. A two-flop synchronizer feeds a mid-bit
//                sampling FSM. Each good byte lands in a one-entry
//                valid/ready output register. Framing errors and overruns
//                are reported as single-cycle registered pulses.
//  Ports       : clk            - system clock, rising edge
//                rst            - asynchronous active-high reset
//                i_rxd          - asynchronous serial line, idles high
//                o_data         - received byte, stable while o_valid
//                o_valid        - byte available
//                i_ready        - consumer accepts when o_valid & i_ready
//                o_busy         - receiver not in IDLE
//                o_frame_error  - pulse: stop bit sampled low
//                o_overrun      - pulse: good byte dropped, held byte pending
//  Parameters  : CLKS_PER_BIT   - clocks per bit, must be >= 4
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_error,
    output logic       o_overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] c_BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    // Synchronizer: both stages reset high so reset never looks like a start bit.
    logic          rxd_meta_q;
    logic          rxd_s_q;

    logic [2:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    idx_q,    idx_d;
    logic [7:0]    shift_q,  shift_d;
    logic [7:0]    data_q,   data_d;
    logic          valid_q,  valid_d;
    logic          ferr_q,   ferr_d;
    logic          ovr_q,    ovr_d;

    logic          w_sample;
    logic          w_good_byte;

    assign w_sample = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
        w_good_byte = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = c_START;
                    cnt_d   = c_HALF_M1;
                end
            end

            c_START: begin
                if (w_sample) begin
                    cnt_d = c_BIT_M1;
                    if (rxd_s_q) begin
                        // Line back high at mid start bit: treat as noise.
                        state_d = c_IDLE;
                    end else begin
                        state_d = c_DATA;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end

            c_DATA: begin
                if (w_sample) begin
                    cnt_d   = c_BIT_M1;
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = c_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end

            c_STOP: begin
                if (w_sample) begin
                    cnt_d = c_BIT_M1;
                    if (rxd_s_q) begin
                        // Leave at mid stop bit so the next start edge is
                        // caught even with a slightly fast transmitter.
                        state_d     = c_IDLE;
                        w_good_byte = 1'b1;
                    end else begin
                        state_d = c_WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end

            c_WAIT_IDLE: begin
                // A held-low line (break) must not decode as repeated 0x00.
                if (rxd_s_q) begin
                    state_d = c_IDLE;
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase

        // One-entry output register. A new byte may overwrite the held byte
        // only when that byte is being accepted on the same edge.
        if (w_good_byte) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rxd_meta_q <= i_rxd;
            rxd_s_q    <= rxd_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_busy        = (state_q != c_IDLE);
    assign o_frame_error = ferr_q;
    assign o_overrun     = ovr_q;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the BIOS command channel. It samples the asynchronous `i_rxd` pin, decodes 8N1 frames LSB-first, and presents each received byte on an AXI-stream-style byte port (`o_data`/`o_valid`/`i_ready`). That port connects directly to the BIOS dispatcher's `i_data`/`i_valid`/`o_in_ready`. A one-entry output register holds the last good byte. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 4. `HALF = CLKS_PER_BIT/2`, integer division.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-high.
- `i_rxd`  in  1: asynchronous UART line; idles high.
- `o_data`  out  8: received byte; stable while `o_valid` is high.
- `o_valid`  out  1: byte available.
- `i_ready`  in  1: consumer accepts the byte when `o_valid & i_ready` at a rising edge.
- `o_busy`  out  1: high in any state other than IDLE.
- `o_frame_error`  out  1: one-cycle pulse when the stop bit is sampled low.
- `o_overrun`  out  1: one-cycle pulse when a good byte completes while the held byte is not being accepted.

## Operation
- **Synchronizer:** two flops on `i_rxd` produce `rxd_s`. Both flops reset to 1, so reset cannot create a false start.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **Bit timer:** `cnt` is a down-counter of width `$clog2(CLKS_PER_BIT)`. A "sample" occurs on the edge where `cnt==0`; that edge also reloads `cnt = CLKS_PER_BIT-1`.
- **IDLE:** when `rxd_s==0` → go to START, load `cnt = HALF-1`.
- **START sample:**
  - `rxd_s==1`: false start → IDLE. No pulse, no output.
  - `rxd_s==0`: → DATA, bit index = 0.
- **DATA sample:** `shift = {rxd_s, shift[7:1]}` (LSB first), then increment the bit index. After the 8th sample → STOP.
- **STOP sample, `rxd_s==1` (good byte):** → IDLE, and write the output register as follows.
  - `o_valid==0`, or `o_valid & i_ready` on this same edge: `o_data <= shift`, `o_valid <= 1`. No overrun.
  - `o_valid & ~i_ready`: keep the old byte, drop the new one, pulse `o_overrun`.
- **STOP sample, `rxd_s==0` (framing error):** discard the byte, pulse `o_frame_error`, → WAIT_IDLE.
- **WAIT_IDLE:** → IDLE on the first cycle with `rxd_s==1`. This prevents a break condition from being decoded as a stream of 0x00 bytes.
- **Output register:** an accept (`o_valid & i_ready` with no simultaneous new byte) clears `o_valid` on that edge. `o_data` is unchanged until the next good byte is written.
- **Line activity during a frame:** changes on the line between samples are ignored. There is no glitch filter beyond the mid-bit sample.

## Timing
- **Reset values:** `o_data=8'h00`, `o_valid=0`, `o_busy=0`, `o_frame_error=0`, `o_overrun=0`, FSM=IDLE, `cnt=0`, synchronizer=2'b11.
- **Reset mid-frame:** immediate return to IDLE, the partial byte is lost, and any held byte is cleared.
- **Detection edge T:** the first edge at which IDLE sees `rxd_s==0`. T is 2 clocks after the pin's falling edge, ±1 for asynchrony.
- **Sample points:**
  - Start bit: T+HALF.
  - Data bit i (0..7): T+HALF+(i+1)·CLKS_PER_BIT.
  - Stop bit: T+HALF+9·CLKS_PER_BIT.
- **Output latency:** `o_valid` is high from the stop-sample edge onward. It is first visible in the cycle after that edge, i.e. T+HALF+9·CLKS_PER_BIT.
- **Pulse timing:** `o_frame_error` and `o_overrun` are registered. Each is high for exactly the one cycle following its stop sample.
- **End of frame:** returning to IDLE at the stop sample, half a bit early, allows back-to-back frames at up to about ±2% baud mismatch.
- **Throughput:** one byte per 10·CLKS_PER_BIT cycles. The consumer has a full frame time to accept each byte before an overrun.

## Test plan
All scenarios use `CLKS_PER_BIT=16` (HALF=8), and frames are driven at exactly 16 clocks per bit.

1. **Single frame:** send 0xA5 with `i_ready` held 1 → `o_valid` is high for 1 cycle with `o_data=8'hA5`, at cycle T+152 (±1); `o_busy` falls at the same time; no error pulses.
2. **Backpressure and overrun:**
   - Send 0x03 then 0x0B back-to-back with `i_ready=0` → `o_data` stays 0x03, `o_valid` stays high, and `o_overrun` pulses once at the end of the 0x0B stop bit.
   - Then raise `i_ready` → 0x03 is accepted and `o_valid` falls.
3. **Simultaneous accept and new byte:** hold 0x07 with `i_ready=0`, then raise `i_ready` on exactly the stop-sample edge of a following 0x42 frame → `o_data=0x42`, `o_valid` stays high, no overrun.
4. **False start:** drive `i_rxd` low for 5 clocks, then high → FSM returns to IDLE at the start sample; `o_valid`, `o_frame_error` and `o_overrun` stay 0.
5. **Framing error:**
   - Send 0x55 with the stop bit low, and hold the line low for 40 more clocks → `o_frame_error` pulses for 1 cycle; no byte is output; `o_busy` stays high until the line returns high.
   - Then send 0x01 → received correctly.
6. **Async reset mid-frame:** assert `rst` during data bit 4 of a frame → all outputs are 0 immediately, without waiting for a clock edge. After release, a fresh 0xFF frame is received correctly.
